// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS      = 2;
    localparam int DEFAULT_ADDR_W = 64;
    localparam int DEFAULT_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef logic port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; the last-grant state lives in the caller.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  port_id_t             last_grant,
    output logic                 grant_valid,
    output port_id_t             grant_id
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = last_grant;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            // Tie: favour whichever port did not win last time.
            2'b11:   grant_id = other_port(last_grant);
            default: grant_id = last_grant;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for data_memory: one access per 3+ cycles, round-robin.
// Optional DMEM_ARB_ALIGN_CHECK_EN rejects addresses with nonzero addr[2:0].
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,

    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    arb_state_t state_reg, state_next;

    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] resp_ready;
    logic [NUM_PORTS-1:0] resp_valid;

    logic        grant_valid;
    port_id_t    grant_id;
    port_id_t    last_grant_reg;
    port_id_t    gid_reg;
    logic        we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              accept;
    logic              misaligned;
    logic              mem_en;

    assign req_valid  = {p1_req_valid, p0_req_valid};
    assign resp_ready = {p1_resp_ready, p0_resp_ready};

    rr_arbiter2 u_rr (
        .valid       (req_valid),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = grant_id ? p1_req_we    : p0_req_we;
    assign sel_addr  = grant_id ? p1_req_addr  : p0_req_addr;
    assign sel_wdata = grant_id ? p1_req_wdata : p0_req_wdata;
    assign accept    = (state_reg == IDLE) && grant_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        resp_valid = '0;
        case (state_reg)
            IDLE: begin
                req_ready[grant_id] = grant_valid;
                if (grant_valid) state_next = ACCESS;
            end
            ACCESS: state_next = RESP;
            RESP: begin
                resp_valid[gid_reg] = 1'b1;
                if (resp_ready[gid_reg]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            gid_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
            rdata_reg      <= '0;
        end else begin
            if (accept) begin
                we_reg         <= sel_we;
                addr_reg       <= sel_addr;
                wdata_reg      <= sel_wdata;
                gid_reg        <= grant_id;
                last_grant_reg <= grant_id;
            end
            if (state_reg == ACCESS) begin
                rdata_reg <= (we_reg || misaligned) ? '0 : read_data;
            end
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic err_reg;

    assign misaligned = (addr_reg[2:0] != 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state_reg == ACCESS) begin
            err_reg <= misaligned;
        end
    end

    assign p0_resp_err = err_reg;
    assign p1_resp_err = err_reg;
`else
    assign misaligned  = 1'b0;
    assign p0_resp_err = 1'b0;
    assign p1_resp_err = 1'b0;
`endif

    // Strobes are pure decode of the state, so reset drops them without a clock.
    assign mem_en     = (state_reg == ACCESS) && !misaligned;
    assign MemRead    = mem_en && !we_reg;
    assign MemWrite   = mem_en && we_reg;
    assign address    = addr_reg;
    assign write_data = wdata_reg;

    assign p0_req_ready  = req_ready[0];
    assign p1_req_ready  = req_ready[1];
    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_rdata = rdata_reg;
    assign p1_resp_rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus random traffic against a reference model.
// Honours DMEM_ARB_ALIGN_CHECK_EN the same way as the design.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [63:0] p0_req_addr, p0_req_wdata;
    logic        p0_resp_valid, p0_resp_ready, p0_resp_err;
    logic [63:0] p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [63:0] p1_req_addr, p1_req_wdata;
    logic        p1_resp_valid, p1_resp_ready, p1_resp_err;
    logic [63:0] p1_resp_rdata;
    logic        MemRead, MemWrite;
    logic [63:0] address, write_data, read_data;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    // Harness data_memory: combinational read, write on rising edge.
    logic [63:0] mem [256];
    assign read_data = mem[address[10:3]];
    always @(posedge clk) begin
        if (MemWrite) mem[address[10:3]] <= write_data;
    end

    // Reference model state.
    logic [63:0] model_mem [256];
    bit          model_last;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
        .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
        .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_misaligned(input logic [63:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        return (a[2:0] != 3'b000);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction; called at posedge+1 with the DUT idle.
    task automatic do_txn(input bit v0, input bit we0, input logic [63:0] a0, input logic [63:0] d0,
                          input bit v1, input bit we1, input logic [63:0] a1, input logic [63:0] d1,
                          input int stall);
        bit          winner;
        bit          w_we;
        bit          mis;
        logic [63:0] w_addr, w_data, exp_rdata;
        int          idx;

        p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
        p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;
        #1;
        winner     = (v0 && v1) ? !model_last : v1;
        model_last = winner;
        w_we   = winner ? we1 : we0;
        w_addr = winner ? a1  : a0;
        w_data = winner ? d1  : d0;
        mis    = is_misaligned(w_addr);
        idx    = int'(w_addr[10:3]);
        chk("p0_req_ready", p0_req_ready, 64'(winner == 1'b0));
        chk("p1_req_ready", p1_req_ready, 64'(winner == 1'b1));

        step();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        #1;
        chk("access_MemWrite", MemWrite, 64'(w_we && !mis));
        chk("access_MemRead", MemRead, 64'(!w_we && !mis));
        chk("access_address", address, w_addr);
        if (w_we) chk("access_write_data", write_data, w_data);
        chk("access_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
        chk("access_readys", 64'({p1_req_ready, p0_req_ready}), 64'd0);

        exp_rdata = (w_we || mis) ? 64'd0 : model_mem[idx];
        if (w_we && !mis) model_mem[idx] = w_data;

        step();
        // The losing port asserting resp_ready must have no effect.
        if (winner) p0_resp_ready = 1'b1; else p1_resp_ready = 1'b1;
        for (int s = 0; s <= stall; s++) begin
            #1;
            chk("resp_valid_winner", winner ? p1_resp_valid : p0_resp_valid, 64'd1);
            chk("resp_valid_other", winner ? p0_resp_valid : p1_resp_valid, 64'd0);
            chk("resp_rdata", winner ? p1_resp_rdata : p0_resp_rdata, exp_rdata);
            chk("resp_err", winner ? p1_resp_err : p0_resp_err, 64'(mis));
            chk("resp_strobes", 64'({MemRead, MemWrite}), 64'd0);
            chk("resp_readys", 64'({p1_req_ready, p0_req_ready}), 64'd0);
            if (s == stall) begin
                if (winner) p1_resp_ready = 1'b1; else p0_resp_ready = 1'b1;
            end
            step();
        end
        p0_resp_ready = 1'b0;
        p1_resp_ready = 1'b0;
        #1;
        chk("idle_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
        $display("txn %0d: port=%0d we=%0d addr=%h wdata=%h rdata_exp=%h err_exp=%0d stall=%0d",
                 txn_no, winner, w_we, w_addr, w_data, exp_rdata, mis, stall);
        txn_no++;
        step();
    endtask

    initial begin
        logic [63:0] ra0, ra1;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 64'd0;
            model_mem[i] = 64'd0;
        end
        model_last    = 1'b1;
        rst_n         = 1'b0;
        p0_req_valid  = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
        p1_req_valid  = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
        p0_resp_ready = 1'b0;
        p1_resp_ready = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_readys", 64'({p1_req_ready, p0_req_ready}), 64'd0);
        chk("rst_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
        chk("rst_rdata", p0_resp_rdata, 64'd0);
        chk("rst_err", 64'({p1_resp_err, p0_resp_err}), 64'd0);
        chk("rst_strobes", 64'({MemRead, MemWrite}), 64'd0);
        chk("rst_address", address, 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        rst_n = 1'b1;
        step();

        // Both ports valid from reset: strict alternation starting with port 0
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0, 0);

        // Store then load on port 0
        do_txn(1'b1, 1'b1, 64'h10, 64'hDEAD, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        do_txn(1'b1, 1'b0, 64'h10, 64'h0,    1'b0, 1'b0, 64'h0, 64'h0, 0);

        // Word 1 gets a known value, then port 1 reads it with a 5-cycle response stall
        do_txn(1'b1, 1'b1, 64'h8, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        do_txn(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0, 5);

        // Misaligned load of 0x0C from port 1
        do_txn(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0C, 64'h0, 1);

        // Random traffic (word 255 reserved for the reset case below)
        for (int n = 0; n < 40; n++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            ra0 = {$urandom, $urandom};
            ra1 = {$urandom, $urandom};
            ra0[10:3] = 8'($urandom_range(0, 254));
            ra1[10:3] = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 5) != 0) ra0[2:0] = 3'd0;
            if ($urandom_range(0, 5) != 0) ra1[2:0] = 3'd0;
            do_txn(v0, 1'($urandom_range(0, 1)), ra0, {$urandom, $urandom},
                   v1, 1'($urandom_range(0, 1)), ra1, {$urandom, $urandom},
                   int'($urandom_range(0, 3)));
        end

        // Reset pulsed during ACCESS of a port-1 store
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 64'h7F8; p1_req_wdata = 64'hBAD;
        #1;
        chk("rstmid_p1_ready", p1_req_ready, 64'd1);
        step();
        p1_req_valid = 1'b0;
        chk("rstmid_MemWrite_before", MemWrite, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_strobes_dropped", 64'({MemRead, MemWrite}), 64'd0);
        step();
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_no_resp", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
        end

        // After reset, port 0 wins the first tie
        do_txn(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 0);
        do_txn(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the 64-bit `data_memory` block. It shares the single data memory between the pipeline load/store path (port 0) and the debug/program-loader path (port 1). It grants one transaction at a time with round-robin fairness and drives `MemRead`/`MemWrite` for exactly one cycle per access. It returns a registered response to the granted port. It sits between the MEM stage / loader and the `data_memory` instance.

## Interface
- `ADDR_W`, 64, request/memory address width
- `DATA_W`, 64, data width

Ports are listed for N ∈ {0,1}; each line exists once per port:
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pN_req_valid`  in  1  request present
- `pN_req_ready`  out  1  arbiter accepts request this cycle
- `pN_req_we`  in  1  1 = store, 0 = load
- `pN_req_addr`  in  ADDR_W  byte address
- `pN_req_wdata`  in  DATA_W  store data
- `pN_resp_valid`  out  1  response available
- `pN_resp_ready`  in  1  requester takes response
- `pN_resp_rdata`  out  DATA_W  load data (0 for stores)
- `pN_resp_err`  out  1  access rejected (see Configuration)
- `MemRead`  out  1  to `data_memory`
- `MemWrite`  out  1  to `data_memory`
- `address`  out  ADDR_W  to `data_memory`
- `write_data`  out  DATA_W  to `data_memory`
- `read_data`  in  DATA_W  from `data_memory`, combinational

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** `pN_req_ready` = 1 only for the port granted this cycle, combinationally from the valids. A single valid port wins. When both are valid, the port not granted last wins. The last-grant register resets to port 1, so port 0 wins the first tie. On handshake, latch we/addr/wdata and the granted id into registers, then go to ACCESS.
- **ACCESS:** drive `address`/`write_data` from the latched registers. `MemWrite` = latched we; `MemRead` = !we. At the clock edge:
  - loads capture `read_data` into the response register;
  - stores capture 0.
  - Go to RESP.
- **RESP:** `pN_resp_valid` = 1 for the granted port only. Hold rdata/err stable until `pN_resp_ready`, then go to IDLE.
- In RESP, new requests are not accepted: both readys are 0.
- Outside ACCESS, `MemRead` = `MemWrite` = 0; `address` and `write_data` still hold their latched values.
- Memory word index is `address[10:3]`. The arbiter passes the full address unchanged; no wrap or range check.
- A requester must hold its valid and fields stable until ready. A request dropped before ready is simply not served.

## Timing
- Accept at edge T, memory strobe during cycle T+1, `resp_valid` from T+2.
- Minimum 3 cycles per transaction; peak throughput is 1 per 3 cycles when `resp_ready` is tied high.
- The non-granted port sees ready = 0 and waits. With both ports continuously valid, it is guaranteed a grant on the next IDLE (strict alternation).
- Reset values: all readys 0 (state IDLE, but no valids are registered); `resp_valid` 0; `resp_rdata` 0; `resp_err` 0; `MemRead`/`MemWrite` 0; `address`/`write_data` 0; last-grant = 1.
- Reset asserted mid-transaction forces IDLE immediately and deasserts both strobes asynchronously. The transaction is dropped and no response is issued. A store interrupted during ACCESS has undefined memory effect.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined: a request with `addr[2:0]` ≠ 0 is accepted normally but does not strobe memory in ACCESS (`MemRead`/`MemWrite` stay 0). Its response has `resp_err` = 1 and `resp_rdata` = 0.
- Undefined: `addr[2:0]` is ignored, every access strobes memory, and `resp_err` is tied to 0.

## Structure
- Package `dmem_arb_pkg`:
  - `NUM_PORTS` = 2;
  - `ADDR_W` / `DATA_W` defaults;
  - state enum `arb_state_t` {IDLE, ACCESS, RESP};
  - `port_id_t` (1 bit).
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from the valids plus the last-grant input. The last-grant register stays in `dmem_arbiter`.

## Test plan
- Port 0 store addr 0x10 data 0xDEAD, then load 0x10 → `MemWrite` high for exactly 1 cycle at T+1; load `resp_rdata` = 0xDEAD at T+2.
- Both ports valid from reset, loads from 0x0 and 0x8 → grants alternate p0, p1, p0, …; each resp_valid appears only on its own port.
- `p1_resp_ready` held 0 for 5 cycles → `p1_resp_valid` and rdata stable; both readys 0; no memory strobes.
- `rst_n` pulsed low during ACCESS of a store → strobes drop immediately; no resp_valid after release; next request is served normally with port 0 winning the first tie.
- Port 1 load addr 0x0C with `DMEM_ARB_ALIGN_CHECK_EN` → no `MemRead`; `resp_err` = 1, rdata 0. Without the macro → `MemRead` pulses, err 0, data = word 1.
